// File: rtl/memory_writeback_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM states,
// common enable constants and small lane/alignment helpers.
package memory_writeback_pkg;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_BUSY = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Byte ops never fault; halves need an even address, words a multiple of 4.
  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] addr_low);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return (addr_low[0] == 1'b0);
      MEM_OP_LW, MEM_OP_SW:             return (addr_low == 2'b00);
      default:                          return 1'b1;
    endcase
  endfunction

  // Big-endian lane mask: bit3 covers bits 31:24 of the memory word.
  function automatic logic [3:0] lane_select(input logic [3:0] op, input logic [1:0] addr_low);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 4'b1000 >> addr_low;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr_low[1] ? 4'b0011 : 4'b1100;
      MEM_OP_LW, MEM_OP_SW:             return 4'b1111;
      default:                          return 4'b0000;
    endcase
  endfunction

  // Replicate store data over every lane so the byte select alone picks it.
  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] data);
    case (op)
      MEM_OP_SB: return {4{data[7:0]}};
      MEM_OP_SH: return {2{data[15:0]}};
      MEM_OP_SW: return data;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/memory_writeback_load_align.sv
// Picks the addressed byte/half out of a big-endian memory word and
// sign- or zero-extends it according to the load op.
module memory_writeback_load_align
  import memory_writeback_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] load_value
);

  logic [7:0]  byte_value;
  logic [15:0] half_value;

  // Lane extraction then extension; unknown ops yield 0.
  always_comb begin
    byte_value = 8'h0;
    half_value = 16'h0;
    load_value = 32'h0;
    case (addr)
      2'd0:    byte_value = mem_read_data[31:24];
      2'd1:    byte_value = mem_read_data[23:16];
      2'd2:    byte_value = mem_read_data[15:8];
      default: byte_value = mem_read_data[7:0];
    endcase
    half_value = addr[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    case (op)
      MEM_OP_LB:  load_value = {{24{byte_value[7]}}, byte_value};
      MEM_OP_LBU: load_value = {24'h0, byte_value};
      MEM_OP_LH:  load_value = {{16{half_value[15]}}, half_value};
      MEM_OP_LHU: load_value = {16'h0, half_value};
      MEM_OP_LW:  load_value = mem_read_data;
      default:    load_value = 32'h0;
    endcase
  end

endmodule

// File: rtl/memory_writeback.sv
// MEM stage: issues data-memory loads/stores over a ready handshake,
// stalls upstream while busy, and drives the registered register-file
// write port (committed by the register file on the following negedge).
//
// Handshake: mem_request stays high with mem_* outputs stable from the
// accept edge until the first edge at which mem_ready=1; that edge ends the
// access. stall_request is high while an aligned memory op waits in IDLE or
// the access is outstanding, and drops in the mem_ready cycle so upstream
// advances on the same edge the access completes.
module memory_writeback
  import memory_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [3:0]            in_memory_op,
  input  logic [DATA_WIDTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  in_write_enable,
  input  logic [4:0]            in_write_address,
  output logic                  stall_request,
  output logic                  address_error,
  output logic                  mem_request,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byte_select,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  write_enable,
  output logic [4:0]            write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output state_t                debug_state
);

  state_t                state;
  logic [3:0]            op_q;
  logic [1:0]            addr_low_q;
  logic                  dest_enable_q;
  logic [4:0]            dest_address_q;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  in_is_memory;
  logic                  in_aligned;

  assign in_is_memory = in_valid && (is_load(in_memory_op) || is_store(in_memory_op));
  assign in_aligned   = is_aligned(in_memory_op, in_address[1:0]);
  assign debug_state  = state;

  // Stall while an aligned access is being accepted or is still outstanding.
  always_comb begin
    stall_request = 1'b0;
    if (state == STATE_IDLE) stall_request = in_is_memory && in_aligned;
    else                     stall_request = !mem_ready;
  end

  memory_writeback_load_align u_load_align (
    .op            (op_q),
    .addr          (addr_low_q),
    .mem_read_data (mem_read_data),
    .load_value    (load_value)
  );

  // Main FSM: accept/issue in IDLE, complete and write back in BUSY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset == RESET_ENABLE) begin
      state           <= STATE_IDLE;
      op_q            <= MEM_OP_NONE;
      addr_low_q      <= 2'b00;
      dest_enable_q   <= WRITE_DISABLE;
      dest_address_q  <= 5'd0;
      address_error   <= 1'b0;
      mem_request     <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_byte_select <= 4'b0000;
      mem_write_data  <= '0;
      write_enable    <= WRITE_DISABLE;
      write_address   <= 5'd0;
      write_data      <= '0;
    end else begin
      address_error <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (!in_valid) begin
            write_enable <= WRITE_DISABLE;
          end else if (!in_is_memory) begin
            // Non-memory (and unknown) ops pass the ALU result straight through.
            write_enable  <= in_write_enable;
            write_address <= in_write_address;
            write_data    <= in_alu_result;
          end else if (!in_aligned) begin
            address_error <= 1'b1;
            write_enable  <= WRITE_DISABLE;
          end else begin
            op_q            <= in_memory_op;
            addr_low_q      <= in_address[1:0];
            dest_enable_q   <= in_write_enable;
            dest_address_q  <= in_write_address;
            mem_request     <= 1'b1;
            mem_write       <= is_store(in_memory_op);
            mem_address     <= {in_address[DATA_WIDTH-1:2], 2'b00};
            mem_byte_select <= lane_select(in_memory_op, in_address[1:0]);
            mem_write_data  <= store_lanes(in_memory_op, in_store_data);
            write_enable    <= WRITE_DISABLE;
            state           <= STATE_BUSY;
          end
        end
        default: begin
          write_enable <= WRITE_DISABLE;
          if (mem_ready) begin
            mem_request <= 1'b0;
            state       <= STATE_IDLE;
            if (is_load(op_q)) begin
              write_enable  <= dest_enable_q;
              write_address <= dest_address_q;
              write_data    <= load_value;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback.sv
// Bench for memory_writeback: a hand-derived vector table, a few
// multi-cycle sequences, and randomized ops checked against a reference
// model; every register-file write is matched against an expected queue.
module tb_memory_writeback;
  import memory_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_memory_op;
  logic [31:0] in_address;
  logic [31:0] in_store_data;
  logic [31:0] in_alu_result;
  logic        in_write_enable;
  logic [4:0]  in_write_address;
  logic        stall_request;
  logic        address_error;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_select;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  state_t      debug_state;

  // kind: 0 = pass-through, 1 = misaligned, 2 = memory access
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] alu;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] rd;
    logic [3:0]  lat;
    logic [1:0]  kind;
    logic [31:0] maddr;
    logic [3:0]  sel;
    logic [31:0] mwdata;
    logic        mw;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  vec_t        tbl[15];
  vec_t        rv;

  // ---------------- clock / reset / DUT ----------------
  always #5 clock = ~clock;

  memory_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_memory_op     (in_memory_op),
    .in_address       (in_address),
    .in_store_data    (in_store_data),
    .in_alu_result    (in_alu_result),
    .in_write_enable  (in_write_enable),
    .in_write_address (in_write_address),
    .stall_request    (stall_request),
    .address_error    (address_error),
    .mem_request      (mem_request),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_byte_select  (mem_byte_select),
    .mem_write_data   (mem_write_data),
    .mem_ready        (mem_ready),
    .mem_read_data    (mem_read_data),
    .write_enable     (write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .debug_state      (debug_state)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: each cycle with write_enable high is one register-file write.
  always @(negedge clock) begin
    if (!reset && write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=%0d:0x%08h expected=none", write_address, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_sb_addr", 32'(write_address), 32'(mon_e[36:32]));
        check("wb_sb_data", write_data, mon_e[31:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic vec_t model(input vec_t v_in);
    vec_t        v;
    int          size;
    int          idx;
    logic        ld;
    logic        st;
    logic        sgn;
    logic [31:0] mask;
    logic [31:0] val;
    v = v_in;
    size = 0; ld = 0; st = 0; sgn = 0;
    case (v.op)
      4'd1: begin ld = 1; size = 1; sgn = 1; end
      4'd2: begin ld = 1; size = 1; end
      4'd3: begin ld = 1; size = 2; sgn = 1; end
      4'd4: begin ld = 1; size = 2; end
      4'd5: begin ld = 1; size = 4; end
      4'd6: begin st = 1; size = 1; end
      4'd7: begin st = 1; size = 2; end
      4'd8: begin st = 1; size = 4; end
      default: size = 0;
    endcase
    idx = int'(v.addr[1:0]);
    v.maddr = 0; v.sel = 0; v.mwdata = 0; v.mw = 0;
    if (size == 0) begin
      v.kind = 0; v.exp_we = v.we; v.exp_data = v.alu;
    end else if (idx % size != 0) begin
      v.kind = 1; v.exp_we = 0; v.exp_data = 0;
    end else begin
      v.kind  = 2;
      v.maddr = v.addr - 32'(idx);
      v.sel   = (size == 4) ? 4'hF : ((size == 2) ? (4'b1100 >> idx) : (4'b1000 >> idx));
      v.mw    = st;
      mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (st) begin
        v.mwdata   = (v.sd & mask) * ((size == 1) ? 32'h0101_0101 : ((size == 2) ? 32'h0001_0001 : 32'd1));
        v.exp_we   = 0;
        v.exp_data = 0;
      end else begin
        val = (v.rd >> (8 * (4 - idx - size))) & mask;
        if (sgn && val[8 * size - 1]) val = val | ~mask;
        v.exp_we   = v.we;
        v.exp_data = val;
      end
    end
    return v;
  endfunction

  function automatic vec_t vec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] alu, input logic we, input logic [4:0] wa,
                               input logic [31:0] rd, input logic [3:0] lat, input logic [1:0] kind,
                               input logic [31:0] maddr, input logic [3:0] sel, input logic [31:0] mwdata,
                               input logic mw, input logic exp_we, input logic [31:0] exp_data);
    vec_t v;
    v.op = op; v.addr = addr; v.sd = sd; v.alu = alu; v.we = we; v.wa = wa; v.rd = rd;
    v.lat = lat; v.kind = kind; v.maddr = maddr; v.sel = sel; v.mwdata = mwdata; v.mw = mw;
    v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input vec_t v);
    in_valid = 1; in_memory_op = v.op; in_address = v.addr; in_store_data = v.sd;
    in_alu_result = v.alu; in_write_enable = v.we; in_write_address = v.wa; mem_ready = 0;
    #1;
    if (v.kind == 0) begin
      check("pass_stall", stall_request, 0);
      if (v.exp_we) exp_q.push_back({v.wa, v.exp_data});
      step();
      check("pass_we", write_enable, v.exp_we);
      check("pass_req", mem_request, 0);
      if (v.exp_we) begin
        check("pass_wa", 32'(write_address), 32'(v.wa));
        check("pass_wd", write_data, v.exp_data);
      end
    end else if (v.kind == 1) begin
      check("mis_stall", stall_request, 0);
      step();
      check("mis_err", address_error, 1);
      check("mis_req", mem_request, 0);
      check("mis_we", write_enable, 0);
      in_valid = 0;
      step();
      check("mis_err_pulse", address_error, 0);
    end else begin
      check("acc_stall", stall_request, 1);
      step();
      check("acc_req", mem_request, 1);
      check("acc_mw", mem_write, v.mw);
      check("acc_addr", mem_address, v.maddr);
      check("acc_sel", 32'(mem_byte_select), 32'(v.sel));
      check("acc_wdata", mem_write_data, v.mwdata);
      check("acc_we", write_enable, 0);
      check("acc_err", address_error, 0);
      for (int i = 0; i < int'(v.lat); i++) begin
        in_memory_op = 4'($urandom_range(0, 15)); in_address = $urandom; in_store_data = $urandom;
        in_alu_result = $urandom; in_write_enable = 1'($urandom_range(0, 1));
        in_write_address = 5'($urandom_range(0, 31)); mem_read_data = $urandom; mem_ready = 0;
        #1;
        check("busy_stall", stall_request, 1);
        step();
        check("busy_req", mem_request, 1);
        check("busy_addr", mem_address, v.maddr);
        check("busy_sel", 32'(mem_byte_select), 32'(v.sel));
        check("busy_wdata", mem_write_data, v.mwdata);
        check("busy_we", write_enable, 0);
      end
      mem_ready = 1; mem_read_data = v.rd;
      #1;
      check("ready_stall", stall_request, 0);
      if (v.exp_we) exp_q.push_back({v.wa, v.exp_data});
      step();
      mem_ready = 0; in_valid = 0;
      check("done_req", mem_request, 0);
      check("done_we", write_enable, v.exp_we);
      if (v.exp_we) begin
        check("done_wa", 32'(write_address), 32'(v.wa));
        check("done_wd", write_data, v.exp_data);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1; in_valid = 0; in_memory_op = 0; in_address = 0; in_store_data = 0;
    in_alu_result = 0; in_write_enable = 0; in_write_address = 0; mem_ready = 0; mem_read_data = 0;

    //            op     addr          sd            alu           we wa rd            lat k  maddr         sel      mwdata        mw ewe edata
    tbl[0]  = vec(4'd0, 32'h0,        32'h0,        32'h12345678, 1, 5, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h12345678);
    tbl[1]  = vec(4'd1, 32'h00000101, 32'h0,        32'h0,        1, 7, 32'h11802233, 3, 2, 32'h00000100, 4'b0100, 32'h0,        0, 1, 32'hFFFFFF80);
    tbl[2]  = vec(4'd2, 32'h00000101, 32'h0,        32'h0,        1, 7, 32'h11802233, 3, 2, 32'h00000100, 4'b0100, 32'h0,        0, 1, 32'h00000080);
    tbl[3]  = vec(4'd7, 32'h00000202, 32'hAAAABEEF, 32'h0,        0, 0, 32'h0,        0, 2, 32'h00000200, 4'b0011, 32'hBEEFBEEF, 1, 0, 32'h0);
    tbl[4]  = vec(4'd5, 32'h00000006, 32'h0,        32'h0,        1, 3, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h0);
    tbl[5]  = vec(4'd5, 32'h00000010, 32'h0,        32'h0,        1, 9, 32'hDEADBEEF, 1, 2, 32'h00000010, 4'b1111, 32'h0,        0, 1, 32'hDEADBEEF);
    tbl[6]  = vec(4'd3, 32'h00000012, 32'h0,        32'h0,        1, 4, 32'h12348001, 2, 2, 32'h00000010, 4'b0011, 32'h0,        0, 1, 32'hFFFF8001);
    tbl[7]  = vec(4'd4, 32'h00000020, 32'h0,        32'h0,        1, 6, 32'h80011234, 0, 2, 32'h00000020, 4'b1100, 32'h0,        0, 1, 32'h00008001);
    tbl[8]  = vec(4'd6, 32'h00000033, 32'h000000A5, 32'h0,        1, 2, 32'h0,        1, 2, 32'h00000030, 4'b0001, 32'hA5A5A5A5, 1, 0, 32'h0);
    tbl[9]  = vec(4'd8, 32'h00000040, 32'hCAFEF00D, 32'h0,        0, 0, 32'h0,        2, 2, 32'h00000040, 4'b1111, 32'hCAFEF00D, 1, 0, 32'h0);
    tbl[10] = vec(4'hF, 32'h00000001, 32'h0,        32'h00000055, 1, 3, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h00000055);
    tbl[11] = vec(4'd7, 32'h00000201, 32'h1234,     32'h0,        0, 0, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h0);
    tbl[12] = vec(4'd1, 32'h00000103, 32'h0,        32'h0,        1, 8, 32'h000000FF, 0, 2, 32'h00000100, 4'b0001, 32'h0,        0, 1, 32'hFFFFFFFF);
    tbl[13] = vec(4'd0, 32'h0,        32'h0,        32'h0BADF00D, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 32'h0);
    tbl[14] = vec(4'd5, 32'h00000000, 32'h0,        32'h0,        1, 0, 32'h00000001, 0, 2, 32'h00000000, 4'b1111, 32'h0,        0, 1, 32'h00000001);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", mem_request, 0);
    check("rst_mw", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_sel", 32'(mem_byte_select), 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_we", write_enable, 0);
    check("rst_wa", 32'(write_address), 0);
    check("rst_wd", write_data, 0);
    check("rst_err", address_error, 0);
    check("rst_state", 32'(debug_state), 32'(STATE_IDLE));
    reset = 0;
    step();

    // Vector table
    for (int i = 0; i < 15; i++) run_op(tbl[i]);

    // in_valid low clears write_enable; mem_ready in IDLE is ignored
    run_op(tbl[0]);
    in_valid = 0; mem_ready = 1;
    #1;
    check("idle_ready_stall", stall_request, 0);
    step();
    check("idle_ready_req", mem_request, 0);
    check("idle_ready_we", write_enable, 0);
    check("idle_ready_state", 32'(debug_state), 32'(STATE_IDLE));
    mem_ready = 0;

    // LW completion immediately followed by a NONE op
    run_op(vec(4'd5, 32'h00000050, 32'h0, 32'h0, 1, 11, 32'h01020304, 1, 2,
               32'h00000050, 4'b1111, 32'h0, 0, 1, 32'h01020304));
    run_op(vec(4'd0, 32'h0, 32'h0, 32'h77777777, 1, 12, 32'h0, 0, 0,
               32'h0, 4'b0000, 32'h0, 0, 1, 32'h77777777));
    in_valid = 0;
    step();
    check("b2b_we_drop", write_enable, 0);

    // Reset in the middle of a BUSY wait abandons the access
    in_valid = 1; in_memory_op = MEM_OP_LW; in_address = 32'h80; in_write_enable = 1; in_write_address = 13;
    step();
    check("mid_rst_req_before", mem_request, 1);
    in_valid = 0;
    step();
    #2;
    reset = 1;
    #1;
    check("mid_rst_req", mem_request, 0);
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_state", 32'(debug_state), 32'(STATE_IDLE));
    step();
    reset = 0; mem_ready = 1; mem_read_data = 32'hFFFFFFFF;
    step();
    check("post_rst_req", mem_request, 0);
    check("post_rst_we", write_enable, 0);
    step();
    check("post_rst_we2", write_enable, 0);
    mem_ready = 0;

    // Randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      rv = '0;
      rv.op   = 4'($urandom_range(0, 15));
      rv.addr = $urandom;
      if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
      rv.sd   = $urandom;
      rv.alu  = $urandom;
      rv.we   = 1'($urandom_range(0, 1));
      rv.wa   = 5'($urandom_range(0, 31));
      rv.rd   = $urandom;
      rv.lat  = 4'($urandom_range(0, 3));
      rv = model(rv);
      run_op(rv);
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 0; mem_ready = 1'($urandom_range(0, 1));
        step();
        check("rand_idle_we", write_enable, 0);
        check("rand_idle_req", mem_request, 0);
        mem_ready = 0;
      end
    end

    in_valid = 0;
    step();
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_writeback.md
Name: memory_writeback

Overview:
- MEM stage of the 5-stage MIPS core, directly upstream of the register file.
- Takes EX/MEM results and performs data-memory loads/stores over a ready-based handshake, stalling the pipeline while memory is busy.
- Aligns and extends load data, then drives a registered write port (write_enable/write_address/write_data) into the register file.
- The register file commits that port on the following negative edge.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; 1 = reset asserted
- in_valid  in  1  EX/MEM holds a valid instruction
- in_memory_op  in  4  MEM_OP_* code from the shared package
- in_address  in  32  effective address (memory ops)
- in_store_data  in  32  rt value for stores
- in_alu_result  in  32  result for non-memory ops
- in_write_enable  in  1  instruction writes a GPR
- in_write_address  in  5  destination GPR
- stall_request  out  1  combinational; upstream holds its inputs while high
- address_error  out  1  registered one-cycle pulse for a misaligned access
- mem_request  out  1  registered; access in progress
- mem_write  out  1  1 = store, 0 = load
- mem_address  out  32  word address {addr[31:2],2'b00}
- mem_byte_select  out  4  active lanes, big-endian (bit3 = bits 31:24)
- mem_write_data  out  32  lane-replicated store data
- mem_ready  in  1  memory completes the access this cycle; read data valid
- mem_read_data  in  32  load word
- write_enable  out  1  registered register-file write enable
- write_address  out  5  registered
- write_data  out  32  registered

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: mem_request, mem_write, mem_address, mem_byte_select, mem_write_data, write_enable, write_address, write_data, address_error.
- Reset mid-access abandons the access immediately and produces no writeback.
- Op codes:
  - NONE: pass-through.
  - LB, LBU, LH, LHU, LW: loads.
  - SB, SH, SW: stores.
  - Any other code is treated as NONE.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- IDLE, in_valid=0: next edge sets write_enable=0.
- IDLE, valid NONE op: no stall. Next edge: write_enable<=in_write_enable, write_address<=in_write_address, write_data<=in_alu_result.
- IDLE, valid misaligned memory op:
  - No stall and no memory request.
  - Next edge: address_error<=1 for one cycle and write_enable<=0.
- IDLE, valid aligned memory op:
  - stall_request=1 combinationally.
  - Next edge: latch op/address/store data/destination; drive mem_* outputs; mem_request<=1; write_enable<=0; state=BUSY.
- BUSY, mem_ready=0: stall_request=1. mem_* outputs are held stable. write_enable stays 0.
- BUSY, mem_ready=1:
  - stall_request=0, so upstream advances at this edge.
  - Next edge: mem_request<=0 and state=IDLE.
  - Load: write_enable<=latched in_write_enable; write_data<=aligned load data.
  - Store: write_enable<=0.
- Minimum memory-op occupancy is 2 cycles (accept, ready). Back-to-back memory ops each take at least 2 cycles.
- mem_ready in IDLE is ignored. in_* changes while BUSY are ignored, because the latched copy is used.
- Byte lanes (big-endian), for addr[1:0] = 0, 1, 2, 3:
  - byte: select 1000, 0100, 0010, 0001.
  - half at addr[1]=0: select 1100; at addr[1]=1: select 0011.
  - word: select 1111.
- Load extraction:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the selected half. LHU: zero-extend it.
  - LW: whole word.
- Store data:
  - SB: {4{data[7:0]}}.
  - SH: {2{data[15:0]}}.
  - SW: data unchanged.
- mem_write_data is 0 for loads.
- Destination $0 is passed through unchanged; the register file discards such writes.

Decomposition:
- Shared defines package: MEM_OP_* codes (4-bit), state encodings STATE_IDLE/STATE_BUSY, and the existing RESET_ENABLE/WRITE_ENABLE-style constants.
- One natural combinational sub-module: load_align. Inputs: op, addr[1:0], mem_read_data. Output: the 32-bit extended load value.
- Store lane/byte-select generation stays inline.

Test Plan:
- NONE op, alu_result=0x12345678, write_enable=1, write_address=5 -> after one edge: write_enable=1, write_address=5, write_data=0x12345678; stall_request=0 throughout.
- LB addr=0x00000101, mem_read_data=0x11802233, mem_ready high 3 cycles after request -> mem_byte_select=0100, mem_address=0x00000100; stall held until the ready cycle; write_data=0xFFFFFF80. With LBU the same stimulus gives 0x00000080.
- SH addr=0x00000202, store_data=0xAAAABEEF, mem_ready immediate -> mem_write=1, mem_byte_select=0011, mem_write_data=0xBEEFBEEF; write_enable stays 0; 2-cycle occupancy.
- LW addr=0x00000006 -> no mem_request; address_error pulses for exactly 1 cycle; write_enable=0; no stall.
- Reset asserted mid-edge-cycle while BUSY waiting on mem_ready -> mem_request=0, write_enable=0, state=IDLE immediately. A later mem_ready=1 is ignored.
- LW completes with mem_ready, immediately followed by a NONE op -> the load writeback appears first, then the NONE writeback on the next edge; no lost or duplicated writes.
